// File: rtl/vip_scheduler.sv
// vip_scheduler
// Arbitrates emergency-vehicle override requests for a two-path intersection.
// One requester at a time is granted in round-robin order. While the grant is
// held, the block drives the override inputs shared by both path light
// controllers. It waits for the lights to show the override has taken effect,
// enforces minimum and maximum hold times, then sequences a release window and
// a cooldown before any new request is considered.
//
// Ports
//   i_clk              rising-edge clock
//   i_rst              synchronous reset, active high
//   i_enable           low forces IDLE and drives every output to its reset value
//   i_vip_req          level request, one bit per requester
//   i_car_traffic_0/1  car light of path 0/1 (RED=1000 YELLOW=0100 LEFT=1010 GREEN=0001)
//   i_walk_traffic_0/1 walk light of path 0/1 (RED=10 GREEN=01 OFF=00)
//   i_prev_counter_0/1 rollback value captured by each path controller
//   o_vip_grant        one-hot grant, zero when nothing is granted
//   o_isvip            override request to both path controllers
//   o_vip_path_index   path that is to receive green
//   o_rollback_cnt     rollback value forwarded to both path controllers
//   o_busy             high in every state except IDLE
//
// State table
//   state      | meaning
//   S_IDLE     | no override; arbitrate pending requests
//   S_ARM      | isvip raised, waiting for lights to engage (bounded)
//   S_ENGAGED  | override confirmed, holding between min and max hold
//   S_RELEASE  | isvip low while light controllers restore their state
//   S_COOLDOWN | requests ignored before returning to IDLE

module vip_scheduler #(
  parameter int                 N_REQ          = 4,
  parameter logic [N_REQ-1:0]   REQ_PATH_MAP   = 4'b1010,
  parameter int                 ARM_TIMEOUT    = 12,
  parameter int                 MIN_HOLD       = 8,
  parameter int                 MAX_HOLD       = 40,
  parameter int                 RELEASE_CYCLES = 3,
  parameter int                 COOLDOWN       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [N_REQ-1:0] i_vip_req,
  input  logic [3:0]       i_car_traffic_0,
  input  logic [3:0]       i_car_traffic_1,
  input  logic [1:0]       i_walk_traffic_0,
  input  logic [1:0]       i_walk_traffic_1,
  input  logic [3:0]       i_prev_counter_0,
  input  logic [3:0]       i_prev_counter_1,
  output logic [N_REQ-1:0] o_vip_grant,
  output logic             o_isvip,
  output logic             o_vip_path_index,
  output logic [3:0]       o_rollback_cnt,
  output logic             o_busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [7:0] ARM_TC  = 8'(ARM_TIMEOUT - 1);
  localparam logic [7:0] MIN_TC  = 8'(MIN_HOLD - 1);
  localparam logic [7:0] MAX_TC  = 8'(MAX_HOLD - 1);
  localparam logic [7:0] REL_TC  = 8'(RELEASE_CYCLES - 1);
  localparam logic [7:0] COOL_TC = 8'(COOLDOWN - 1);

  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  localparam logic [3:0] CAR_RED   = 4'b1000;
  localparam logic [3:0] CAR_GREEN = 4'b0001;
  localparam logic [1:0] WALK_RED  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_ENGAGED,
    S_RELEASE,
    S_COOLDOWN
  } state_t;

  state_t        r_state;
  logic [7:0]    r_timer;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_gidx;

  logic          w_found;
  logic [PW-1:0] w_pick;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_req_g;
  logic          w_engaged;
  logic [3:0]    w_vip_car;
  logic [3:0]    w_other_car;
  logic [3:0]    w_rb;

  // Round-robin search: walk the offsets from the highest down so the
  // smallest offset from the pointer is the one that sticks.
  always_comb begin
    logic [PW-1:0] v_idx;
    w_found = 1'b0;
    w_pick  = '0;
    v_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      v_idx = PW'((int'(r_ptr) + k) % N_REQ);
      if (i_vip_req[v_idx]) begin
        w_found = 1'b1;
        w_pick  = v_idx;
      end
    end
  end

  assign w_ptr_nxt = (int'(w_pick) == N_REQ - 1) ? '0 : w_pick + 1'b1;

  assign w_req_g     = i_vip_req[r_gidx];
  assign w_vip_car   = o_vip_path_index ? i_car_traffic_1 : i_car_traffic_0;
  assign w_other_car = o_vip_path_index ? i_car_traffic_0 : i_car_traffic_1;
  assign w_engaged   = (w_vip_car == CAR_GREEN) && (w_other_car == CAR_RED) &&
                       (i_walk_traffic_0 == WALK_RED) && (i_walk_traffic_1 == WALK_RED);

  // Path 0's controller reports zero when it was not the one interrupted.
  assign w_rb = (i_prev_counter_0 != 4'd0) ? i_prev_counter_0 : i_prev_counter_1;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_state          <= S_IDLE;
      r_timer          <= '0;
      r_ptr            <= '0;
      r_gidx           <= '0;
      o_vip_grant      <= '0;
      o_isvip          <= 1'b0;
      o_vip_path_index <= 1'b0;
      o_rollback_cnt   <= 4'd0;
      o_busy           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (w_found) begin
            r_state          <= S_ARM;
            r_gidx           <= w_pick;
            r_ptr            <= w_ptr_nxt;
            o_vip_grant      <= ONE_HOT0 << w_pick;
            o_isvip          <= 1'b1;
            o_busy           <= 1'b1;
            o_vip_path_index <= REQ_PATH_MAP[w_pick];
          end
        end

        S_ARM: begin
          if (w_engaged) begin
            r_state        <= S_ENGAGED;
            r_timer        <= '0;
            o_rollback_cnt <= w_rb;
          end else if (!w_req_g || r_timer == ARM_TC) begin
            r_state        <= S_RELEASE;
            r_timer        <= '0;
            o_rollback_cnt <= w_rb;
            o_isvip        <= 1'b0;
            o_vip_grant    <= '0;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        S_ENGAGED: begin
          // A request dropped early is still held until the minimum hold.
          if ((!w_req_g && r_timer >= MIN_TC) || r_timer == MAX_TC) begin
            r_state     <= S_RELEASE;
            r_timer     <= '0;
            o_isvip     <= 1'b0;
            o_vip_grant <= '0;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        S_RELEASE: begin
          if (r_timer == REL_TC) begin
            r_state        <= S_COOLDOWN;
            r_timer        <= '0;
            o_rollback_cnt <= 4'd0;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        S_COOLDOWN: begin
          if (r_timer == COOL_TC) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            o_busy  <= 1'b0;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vip_scheduler.sv
// Bench for vip_scheduler. Each override is one transaction: the stimulus
// pushes the hand-computed expectation before raising the request, and the
// monitor measures the observed transaction (grant, path, cycles with isvip
// high, cycles busy with isvip low, rollback value) and compares on busy fall.
// A light-controller model engages the VIP path 3 cycles after isvip rises.

module tb_vip_scheduler;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] vip_req;
  logic [3:0] car0, car1;
  logic [1:0] walk0, walk1;
  logic [3:0] prev0, prev1;
  logic [3:0] grant;
  logic       isvip;
  logic       path;
  logic [3:0] rb;
  logic       busy;

  bit engage_en;
  int checks;
  int failures;

  typedef struct {
    logic [3:0] grant;
    logic       path;
    int         hi;
    int         post;
    bit         chk_rb;
    logic [3:0] rb;
    bit         abort;
  } exp_t;

  exp_t exp_q[$];
  bit   in_txn;

  vip_scheduler dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_enable         (enable),
    .i_vip_req        (vip_req),
    .i_car_traffic_0  (car0),
    .i_car_traffic_1  (car1),
    .i_walk_traffic_0 (walk0),
    .i_walk_traffic_1 (walk1),
    .i_prev_counter_0 (prev0),
    .i_prev_counter_1 (prev1),
    .o_vip_grant      (grant),
    .o_isvip          (isvip),
    .o_vip_path_index (path),
    .o_rollback_cnt   (rb),
    .o_busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic p, input int hi, input int post,
                      input bit chk_rb, input logic [3:0] r, input bit abort);
    exp_t e;
    e.grant = g; e.path = p; e.hi = hi; e.post = post;
    e.chk_rb = chk_rb; e.rb = r; e.abort = abort;
    exp_q.push_back(e);
  endtask

  // which: 0 = isvip, 1 = busy. Bounded wait on negedges.
  task automatic wait_for(input int which, input logic val, input string name);
    int n;
    n = 0;
    while (((which == 0) ? isvip : busy) !== val && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (((which == 0) ? isvip : busy) !== val) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s actual=%0d expected=%0d", name,
               (which == 0) ? isvip : busy, val);
    end
  endtask

  // Light controller model: engages 3 cycles after isvip rises when allowed.
  initial begin
    int icnt;
    icnt  = 0;
    car0  = 4'b0001;
    car1  = 4'b1000;
    walk0 = 2'b10;
    walk1 = 2'b01;
    forever begin
      @(negedge clk);
      if (isvip === 1'b1) icnt++;
      else icnt = 0;
      if (isvip === 1'b1 && engage_en && icnt >= 3) begin
        if (path === 1'b1) begin
          car1 = 4'b0001; car0 = 4'b1000;
        end else begin
          car0 = 4'b0001; car1 = 4'b1000;
        end
        walk0 = 2'b10;
        walk1 = 2'b10;
      end else begin
        car0  = 4'b0001;
        car1  = 4'b1000;
        walk0 = 2'b10;
        walk1 = 2'b01;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t       cur;
    bit         have_exp;
    int         hi, post, herr, perr;
    logic [3:0] rb_rel, rb_cool;
    in_txn   = 1'b0;
    have_exp = 1'b0;
    hi = 0; post = 0; herr = 0; perr = 0;
    rb_rel = '0; rb_cool = '0;
    forever begin
      @(negedge clk);
      if (!in_txn && busy === 1'b1) begin
        in_txn = 1'b1;
        hi = 0; post = 0; herr = 0; perr = 0;
        rb_rel = 4'hx; rb_cool = 4'hx;
        if (exp_q.size() == 0) begin
          have_exp = 1'b0;
          checks++;
          failures++;
          $display("FAIL unexpected_grant actual=%0d expected=none", grant);
        end else begin
          have_exp = 1'b1;
          cur = exp_q.pop_front();
          chk("grant_first", grant, cur.grant);
          chk("path_first", path, cur.path);
          chk("isvip_first", isvip, 1'b1);
        end
      end
      if (in_txn) begin
        if (busy === 1'b1) begin
          if (isvip === 1'b1) begin
            hi++;
            if (have_exp && (grant !== cur.grant || path !== cur.path)) herr++;
          end else begin
            post++;
            if (have_exp && (grant !== 4'd0 || path !== cur.path)) perr++;
            if (post == 3) rb_rel = rb;
            if (post == 4) rb_cool = rb;
          end
        end else begin
          in_txn = 1'b0;
          if (have_exp) begin
            chk("grant_hold_errs", herr, 0);
            chk("release_hold_errs", perr, 0);
            chk("isvip_cycles", hi, cur.hi);
            chk("busy_isvip_low_cycles", post, cur.post);
            if (cur.chk_rb) begin
              chk("rollback_in_release", rb_rel, cur.rb);
              chk("rollback_in_cooldown", rb_cool, 4'd0);
            end
            chk("idle_outputs", {grant, isvip, rb}, 9'd0);
            if (cur.abort) chk("idle_path_cleared", path, 1'b0);
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int n;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    enable    = 1'b1;
    vip_req   = 4'd0;
    prev0     = 4'b0011;
    prev1     = 4'b0101;
    engage_en = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_grant", grant, 4'd0);
    chk("reset_isvip", isvip, 1'b0);
    chk("reset_path", path, 1'b0);
    chk("reset_rollback", rb, 4'd0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic override: drop request 20 cycles after isvip rises.
    push(4'b0010, 1'b1, 21, 19, 1'b1, 4'b0011, 1'b0);
    vip_req = 4'b0010;
    wait_for(0, 1'b1, "basic_rise");
    repeat (20) @(negedge clk);
    vip_req = 4'd0;
    wait_for(1, 1'b0, "basic_done");

    // Max hold: request held forever.
    push(4'b0100, 1'b0, 43, 19, 1'b1, 4'b0011, 1'b0);
    vip_req = 4'b0100;
    wait_for(0, 1'b1, "max_rise");
    wait_for(0, 1'b0, "max_fall");
    vip_req = 4'd0;
    wait_for(1, 1'b0, "max_done");

    // Min hold: request dropped after 2 engaged cycles.
    push(4'b1000, 1'b1, 11, 19, 1'b1, 4'b0011, 1'b0);
    vip_req = 4'b1000;
    wait_for(0, 1'b1, "min_rise");
    repeat (5) @(negedge clk);
    vip_req = 4'd0;
    wait_for(1, 1'b0, "min_done");

    // Arm timeout, rollback from path 0 then from path 1.
    engage_en = 1'b0;
    push(4'b0001, 1'b0, 12, 19, 1'b1, 4'b0011, 1'b0);
    vip_req = 4'b0001;
    wait_for(0, 1'b1, "arm0_rise");
    wait_for(0, 1'b0, "arm0_fall");
    vip_req = 4'd0;
    wait_for(1, 1'b0, "arm0_done");
    prev0 = 4'd0;
    push(4'b0010, 1'b1, 12, 19, 1'b1, 4'b0101, 1'b0);
    vip_req = 4'b0010;
    wait_for(0, 1'b1, "arm1_rise");
    wait_for(0, 1'b0, "arm1_fall");
    vip_req = 4'd0;
    wait_for(1, 1'b0, "arm1_done");
    prev0 = 4'b0011;
    engage_en = 1'b1;

    // Round robin from a reset pointer.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(4'b0001, 1'b0, 43, 19, 1'b1, 4'b0011, 1'b0);
    push(4'b0010, 1'b1, 43, 19, 1'b1, 4'b0011, 1'b0);
    push(4'b0100, 1'b0, 43, 19, 1'b1, 4'b0011, 1'b0);
    push(4'b1000, 1'b1, 43, 19, 1'b1, 4'b0011, 1'b0);
    push(4'b0001, 1'b0, 43, 19, 1'b1, 4'b0011, 1'b0);
    vip_req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      wait_for(0, 1'b1, "rr_rise");
      wait_for(0, 1'b0, "rr_fall");
    end
    vip_req = 4'd0;
    wait_for(1, 1'b0, "rr_done");

    // Disable mid-ENGAGED (pointer was 1), then reset mid-RELEASE.
    push(4'b0010, 1'b1, 7, 0, 1'b0, 4'd0, 1'b1);
    vip_req = 4'b1111;
    wait_for(0, 1'b1, "dis_rise");
    repeat (6) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    push(4'b0001, 1'b0, 11, 1, 1'b0, 4'd0, 1'b1);
    enable = 1'b1;
    wait_for(0, 1'b1, "rst_rise");
    repeat (5) @(negedge clk);
    vip_req = 4'd0;
    wait_for(0, 1'b0, "rst_fall");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(4'b0001, 1'b0, 43, 19, 1'b1, 4'b0011, 1'b0);
    vip_req = 4'b1111;
    wait_for(0, 1'b1, "post_rst_rise");
    wait_for(0, 1'b0, "post_rst_fall");
    vip_req = 4'd0;
    wait_for(1, 1'b0, "post_rst_done");

    n = 0;
    while ((in_txn || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
